divide_float: RTL

- Iterative multi-cycle floating-point divider (outf = in1 / in2) in the ALU's 16-bit float format.
- Format: sign [15], exponent [14:7] with bias 127, mantissa [6:0] with implicit leading 1.
- Inverse counterpart of the combinational float multiplier: truncating arithmetic, same zero convention.
- Planned as the DIVF execution unit; the pipeline stalls on busy and captures the result on done.

---
 rtl/float_pkg.sv | 32 +++
 rtl/mant_div_step.sv | 33 +++
 rtl/divide_float.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
//==============================================================================
// Module      : float_pkg
// Description : Shared definitions for the ALU 16-bit float format
//               (sign[15], exponent[14:7] bias 127, mantissa[6:0] hidden 1)
//               and the state encoding of the iterative divider.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package float_pkg;

  // Field widths and bias of the ALU float format
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 7;
  localparam int EXP_BIAS = 127;
  localparam int FP_WIDTH = 1 + EXP_W + MANT_W;

  // Canonical encodings shared with the float multiplier
  localparam logic [FP_WIDTH-1:0] FP_ZERO    = 16'h0000;
  localparam logic [FP_WIDTH-1:0] FP_INF_POS = 16'h7F80;

  // Divider control states
  localparam int         ST_W       = 2;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIVIDE  = 2'd1;
  localparam logic [1:0] ST_NORM    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mant_div_step.sv
//==============================================================================
// Module      : mant_div_step
// Description : One combinational restoring-division step. Emits the quotient
//               bit (rem >= d), subtracts the divisor when it fits, and
//               shifts the partial remainder left for the next step.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mant_div_step
  import float_pkg::*;
#(
  parameter int REM_W = MANT_W + 3
) (
  input  logic [REM_W-1:0] rem,
  input  logic [REM_W-1:0] d,
  output logic [REM_W-1:0] rem_next,
  output logic             q_bit
);

  logic [REM_W-1:0] diff;

  // Restoring step: the remainder stays below 2*d, so the shift never loses a set bit
  always_comb begin
    q_bit    = (rem >= d);
    diff     = q_bit ? (rem - d) : rem;
    rem_next = diff << 1;
  end

endmodule

`default_nettype wire

// File: rtl/divide_float.sv
//==============================================================================
// Module      : divide_float
// Description : Iterative multi-cycle float divider (outf = in1 / in2).
//               Nine restoring steps, one normalize cycle, truncating result.
//               busy/done are registered, so done rises 11 edges after the
//               accepting edge regardless of operand values.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module divide_float #(
  parameter int EXP_BIAS = float_pkg::EXP_BIAS,
  parameter int MANT_W   = float_pkg::MANT_W,
  parameter int WIDTH    = 1 + float_pkg::EXP_W + MANT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outf,
  output logic             div_zero,
  output logic             ovf,
  output logic             unf
);

  import float_pkg::EXP_W;
  import float_pkg::FP_ZERO;
  import float_pkg::FP_INF_POS;
  import float_pkg::ST_W;
  import float_pkg::ST_IDLE;
  import float_pkg::ST_DIVIDE;
  import float_pkg::ST_NORM;
  import float_pkg::ST_DONE;

  localparam int Q_W   = MANT_W + 2;   // quotient bits, value in [0.5, 2)
  localparam int REM_W = MANT_W + 3;   // partial remainder width
  localparam int CNT_W = 4;
  localparam int E_W   = EXP_W + 2;    // signed working exponent

  localparam logic        [E_W-1:0]   BIAS_E   = E_W'(EXP_BIAS);
  localparam logic signed [E_W-1:0]   E_MAX    = E_W'((1 << EXP_W) - 2);
  localparam logic signed [E_W-1:0]   E_MIN    = E_W'(1);
  localparam logic        [CNT_W-1:0] LAST_CNT = CNT_W'(Q_W - 1);

  logic [ST_W-1:0]   state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [REM_W-1:0]  rem_q,      rem_d;
  logic [MANT_W:0]   dvs_q,      dvs_d;
  logic [Q_W-1:0]    quo_q,      quo_d;
  logic [E_W-1:0]    exp_q,      exp_d;
  logic              sign_q,     sign_d;
  logic              a_zero_q,   a_zero_d;
  logic              b_zero_q,   b_zero_d;
  logic [WIDTH-1:0]  outf_q,     outf_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q,      ovf_d;
  logic              unf_q,      unf_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  logic [REM_W-1:0]  rem_next;
  logic              q_bit;
  logic [E_W-1:0]    exp_n;
  logic [MANT_W-1:0] mant_n;

  mant_div_step #(
    .REM_W (REM_W)
  ) u_step (
    .rem      (rem_q),
    .d        (REM_W'(dvs_q)),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Next-state logic: operand capture, iteration, normalize/special cases
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    a_zero_d   = a_zero_q;
    b_zero_d   = b_zero_q;
    outf_d     = outf_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    // A quotient below 1.0 needs one extra left shift and an exponent decrement
    mant_n = quo_q[Q_W-1] ? quo_q[Q_W-2:1] : quo_q[Q_W-3:0];
    exp_n  = quo_q[Q_W-1] ? exp_q : (exp_q - E_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DIVIDE;
          sign_d     = in1[WIDTH-1] ^ in2[WIDTH-1];
          exp_d      = E_W'(in1[WIDTH-2 -: EXP_W]) - E_W'(in2[WIDTH-2 -: EXP_W]) + BIAS_E;
          rem_d      = REM_W'({1'b1, in1[MANT_W-1:0]});
          dvs_d      = {1'b1, in2[MANT_W-1:0]};
          quo_d      = '0;
          cnt_d      = '0;
          a_zero_d   = (in1[WIDTH-2:0] == '0);
          b_zero_d   = (in2[WIDTH-2:0] == '0);
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
        end
      end
      ST_DIVIDE: begin
        rem_d = rem_next;
        quo_d = {quo_q[Q_W-2:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        state_d = ST_DONE;
        if (b_zero_q) begin
          outf_d     = WIDTH'(FP_INF_POS) | {sign_q, {(WIDTH-1){1'b0}}};
          div_zero_d = 1'b1;
        end else if (a_zero_q) begin
          outf_d = WIDTH'(FP_ZERO);
        end else if ($signed(exp_n) > E_MAX) begin
          outf_d = WIDTH'(FP_INF_POS) | {sign_q, {(WIDTH-1){1'b0}}};
          ovf_d  = 1'b1;
        end else if ($signed(exp_n) < E_MIN) begin
          outf_d = WIDTH'(FP_ZERO);
          unf_d  = 1'b1;
        end else begin
          outf_d = {sign_q, exp_n[EXP_W-1:0], mant_n};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs trail the state by one cycle
    busy_d = (state_q == ST_DIVIDE) || (state_q == ST_NORM);
    done_d = (state_q == ST_DONE);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      a_zero_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      outf_q     <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      a_zero_q   <= a_zero_d;
      b_zero_q   <= b_zero_d;
      outf_q     <= outf_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign outf     = outf_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

`default_nettype wire
